// File: rtl/parking_gate_ctrl.sv
// Parking lot entry/exit sequencer: occupancy tracking, password-gated entry,
// gate drive and seven-segment message select (00 Full, 01 Enter, 10 Error, 11 blank).
// Optional lockout after three consecutive password failures: PARKING_LOCKOUT_EN.
module parking_gate_ctrl #(
  parameter int unsigned CAPACITY   = 8,
  parameter logic [3:0]  PW         = 4'b1010,
  parameter int unsigned MSG_HOLD   = 50_000_000,
  parameter int unsigned PW_TIMEOUT = 250_000_000,
  localparam int unsigned OccW      = $clog2(CAPACITY + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enter_req,
  input  logic            exit_req,
  input  logic [3:0]      pw_in,
  input  logic            pw_valid,
  output logic [1:0]      segstate,
  output logic            gate_open,
  output logic [OccW-1:0] occupancy,
  output logic            full
);

  localparam logic [31:0]     HoldLast = 32'(MSG_HOLD - 1);
  localparam logic [31:0]     PwLast   = 32'(PW_TIMEOUT - 1);
  localparam logic [OccW-1:0] OccOne   = OccW'(1);
  localparam logic [OccW-1:0] OccCap   = OccW'(CAPACITY);
`ifdef PARKING_LOCKOUT_EN
  localparam logic [31:0]     LockLast = 32'(4 * MSG_HOLD - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StWaitPw,
    StEnter,
    StError
`ifdef PARKING_LOCKOUT_EN
    , StLock
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     timer_q, timer_d;
  logic            prev_enter_q, prev_exit_q;
  logic [1:0]      segstate_q, segstate_d;
  logic            gate_open_q, gate_open_d;
  logic [OccW-1:0] occupancy_q, occupancy_d;
  logic            full_q, full_d;
`ifdef PARKING_LOCKOUT_EN
  logic [1:0]      fail_cnt_q, fail_cnt_d;
`endif

  logic enter_edge, exit_edge, pw_ok, pw_fail, inc, dec;

  // Next-state, occupancy and registered-output computation
  always_comb begin
    enter_edge = enter_req & ~prev_enter_q;
    exit_edge  = exit_req & ~prev_exit_q;
    pw_ok      = pw_valid && (pw_in == PW);
    // A pw_valid on the timeout cycle takes priority over the timeout
    pw_fail    = pw_valid ? (pw_in != PW) : (timer_q == PwLast);
    state_d    = state_q;
    inc        = 1'b0;
`ifdef PARKING_LOCKOUT_EN
    fail_cnt_d = fail_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (enter_edge && !full_q) state_d = StWaitPw;
      end
      StWaitPw: begin
        if (pw_ok) begin
          state_d = StEnter;
          inc     = 1'b1;
`ifdef PARKING_LOCKOUT_EN
          fail_cnt_d = 2'd0;
`endif
        end else if (pw_fail) begin
`ifdef PARKING_LOCKOUT_EN
          fail_cnt_d = fail_cnt_q + 2'd1;
          state_d    = (fail_cnt_q == 2'd2) ? StLock : StError;
`else
          state_d = StError;
`endif
        end
      end
      StEnter, StError: begin
        if (timer_q == HoldLast) state_d = StIdle;
      end
`ifdef PARKING_LOCKOUT_EN
      StLock: begin
        if (timer_q == LockLast) begin
          state_d    = StIdle;
          fail_cnt_d = 2'd0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Timer restarts on every state change and idles at zero
    if ((state_d != state_q) || (state_q == StIdle)) timer_d = '0;
    else                                             timer_d = timer_q + 32'd1;

    dec = exit_edge && (occupancy_q != '0);
    case ({inc, dec})
      2'b10:   occupancy_d = occupancy_q + OccOne;
      2'b01:   occupancy_d = occupancy_q - OccOne;
      default: occupancy_d = occupancy_q;
    endcase
    full_d = (occupancy_d == OccCap);

    gate_open_d = (state_d == StEnter);
    case (state_d)
      StIdle:   segstate_d = full_d ? 2'b00 : 2'b11;
      StEnter:  segstate_d = 2'b01;
      StError:  segstate_d = 2'b10;
`ifdef PARKING_LOCKOUT_EN
      StLock:   segstate_d = 2'b10;
`endif
      default:  segstate_d = 2'b11;
    endcase
  end

  // State, timer, edge-detect and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      prev_enter_q <= 1'b0;
      prev_exit_q  <= 1'b0;
      segstate_q   <= 2'b11;
      gate_open_q  <= 1'b0;
      occupancy_q  <= '0;
      full_q       <= 1'b0;
`ifdef PARKING_LOCKOUT_EN
      fail_cnt_q   <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      prev_enter_q <= enter_req;
      prev_exit_q  <= exit_req;
      segstate_q   <= segstate_d;
      gate_open_q  <= gate_open_d;
      occupancy_q  <= occupancy_d;
      full_q       <= full_d;
`ifdef PARKING_LOCKOUT_EN
      fail_cnt_q   <= fail_cnt_d;
`endif
    end
  end

  assign segstate  = segstate_q;
  assign gate_open = gate_open_q;
  assign occupancy = occupancy_q;
  assign full      = full_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed self-checking bench for parking_gate_ctrl (CAPACITY=2, MSG_HOLD=4, PW_TIMEOUT=10).
module tb_parking_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [3:0] pw_in = 4'b0000;
  logic       pw_valid = 1'b0;
  logic [1:0] segstate;
  logic       gate_open;
  logic [1:0] occupancy;
  logic       full;

  int n_vec = 0;
  int n_err = 0;

  parking_gate_ctrl #(
    .CAPACITY  (2),
    .PW        (4'b1010),
    .MSG_HOLD  (4),
    .PW_TIMEOUT(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enter_req(enter_req),
    .exit_req (exit_req),
    .pw_in    (pw_in),
    .pw_valid (pw_valid),
    .segstate (segstate),
    .gate_open(gate_open),
    .occupancy(occupancy),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] seg, input logic gate,
                         input logic [1:0] occ, input logic f);
    chk({tag, ".seg"}, 32'(segstate), 32'(seg));
    chk({tag, ".gate"}, 32'(gate_open), 32'(gate));
    chk({tag, ".occ"}, 32'(occupancy), 32'(occ));
    chk({tag, ".full"}, 32'(full), 32'(f));
  endtask

  // Checks n hold cycles of the given message, ending one cycle into the following state
  task automatic hold_chk(input string tag, input logic [1:0] seg, input logic gate, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, ".hold_seg"}, 32'(segstate), 32'(seg));
      chk({tag, ".hold_gate"}, 32'(gate_open), 32'(gate));
      tick();
    end
  endtask

  // Enter edge, then one pw_valid pulse; returns in the first cycle of ENTER/ERROR
  task automatic enter_pw(input string tag, input logic [3:0] pw);
    enter_req = 1'b1;
    tick();
    enter_req = 1'b0;
    chk({tag, ".waitpw_seg"}, 32'(segstate), 32'(2'b11));
    pw_in    = pw;
    pw_valid = 1'b1;
    tick();
    pw_valid = 1'b0;
  endtask

  initial begin
    // Reset and idle
    tick();
    tick();
    chk_all("reset", 2'b11, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_all("idle5", 2'b11, 1'b0, 2'd0, 1'b0);

    // First good entry
    enter_pw("entry1", 4'b1010);
    chk_all("entry1", 2'b01, 1'b1, 2'd1, 1'b0);
    hold_chk("entry1", 2'b01, 1'b1, 4);
    chk_all("entry1_idle", 2'b11, 1'b0, 2'd1, 1'b0);

    // Second entry fills the lot
    enter_pw("entry2", 4'b1010);
    chk_all("entry2", 2'b01, 1'b1, 2'd2, 1'b1);
    hold_chk("entry2", 2'b01, 1'b1, 4);
    chk_all("full_idle", 2'b00, 1'b0, 2'd2, 1'b1);

    // Enter edge while full is ignored, and so is a stray pw_valid
    enter_req = 1'b1;
    tick();
    enter_req = 1'b0;
    chk_all("enter_full", 2'b00, 1'b0, 2'd2, 1'b1);
    pw_in    = 4'b1010;
    pw_valid = 1'b1;
    tick();
    pw_valid = 1'b0;
    chk_all("pw_in_idle", 2'b00, 1'b0, 2'd2, 1'b1);

    // Exit frees a space
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    chk_all("exit1", 2'b11, 1'b0, 2'd1, 1'b0);
    tick();

    // Wrong password
    enter_pw("badpw", 4'b0101);
    chk_all("badpw", 2'b10, 1'b0, 2'd1, 1'b0);
    hold_chk("badpw", 2'b10, 1'b0, 4);
    chk_all("badpw_idle", 2'b11, 1'b0, 2'd1, 1'b0);

    // Password timeout: WAIT_PW lasts exactly 10 cycles
    enter_req = 1'b1;
    tick();
    enter_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("timeout_wait_seg", 32'(segstate), 32'(2'b11));
    end
    tick();
    chk_all("timeout", 2'b10, 1'b0, 2'd1, 1'b0);
    hold_chk("timeout", 2'b10, 1'b0, 4);
    chk_all("timeout_idle", 2'b11, 1'b0, 2'd1, 1'b0);

    // pw_valid on the timeout cycle wins
    enter_req = 1'b1;
    tick();
    enter_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("tcycle_wait_seg", 32'(segstate), 32'(2'b11));
    pw_in    = 4'b1010;
    pw_valid = 1'b1;
    tick();
    pw_valid = 1'b0;
    chk_all("tcycle_accept", 2'b01, 1'b1, 2'd2, 1'b1);
    hold_chk("tcycle", 2'b01, 1'b1, 4);
    chk_all("tcycle_idle", 2'b00, 1'b0, 2'd2, 1'b1);

    // Back to one car, then simultaneous entry increment and exit decrement
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    chk_all("exit2", 2'b11, 1'b0, 2'd1, 1'b0);
    enter_req = 1'b1;
    tick();
    enter_req = 1'b0;
    pw_in    = 4'b1010;
    pw_valid = 1'b1;
    exit_req = 1'b1;
    tick();
    pw_valid = 1'b0;
    exit_req = 1'b0;
    chk_all("simul", 2'b01, 1'b1, 2'd1, 1'b0);
    hold_chk("simul", 2'b01, 1'b1, 4);

    // Exits down to zero, then an exit at zero is ignored
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    chk_all("exit_to0", 2'b11, 1'b0, 2'd0, 1'b0);
    tick();
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    chk_all("exit_at0", 2'b11, 1'b0, 2'd0, 1'b0);

    // Reset during ENTER
    enter_pw("rst_entry", 4'b1010);
    chk_all("rst_entry", 2'b01, 1'b1, 2'd1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk_all("rst_mid", 2'b11, 1'b0, 2'd0, 1'b0);

    // Request held across reset release yields one edge on the first cycle
    enter_req = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pw_in    = 4'b1010;
    pw_valid = 1'b1;
    tick();
    pw_valid  = 1'b0;
    enter_req = 1'b0;
    chk_all("held_req", 2'b01, 1'b1, 2'd1, 1'b0);
    hold_chk("held_req", 2'b01, 1'b1, 4);

    // Three consecutive failures after a clean reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      enter_pw("fail12", 4'b0101);
      hold_chk("fail12", 2'b10, 1'b0, 4);
      chk("fail12_idle", 32'(segstate), 32'(2'b11));
    end
    enter_pw("fail3", 4'b0101);
`ifdef PARKING_LOCKOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk("lock_seg", 32'(segstate), 32'(2'b10));
      enter_req = (i == 5);
      tick();
    end
    enter_req = 1'b0;
    chk("lock_idle", 32'(segstate), 32'(2'b11));
    tick();
    chk("lock_idle2", 32'(segstate), 32'(2'b11));
`else
    hold_chk("fail3", 2'b10, 1'b0, 4);
    chk_all("fail3_idle", 2'b11, 1'b0, 2'd0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Entry/exit sequencer for the parking controller. It tracks lot occupancy, runs the password-gated entry sequence and drives the gate. It also selects the message shown by the seven-segment display driver through the 2-bit `segstate` code: 00 Full, 01 Enter, 10 Error, 11 blank. It sits between the board buttons/switches and the display driver, and is the only writer of `segstate`.

## Interface
Parameters:
- `CAPACITY`, 8: number of spaces; occupancy saturates here.
- `PW`, 4'b1010: entry password compared against `pw_in`.
- `MSG_HOLD`, 50_000_000: cycles an Enter/Error message (and open gate) is held.
- `PW_TIMEOUT`, 250_000_000: cycles allowed in password wait before Error.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `enter_req` in 1: entry button, level; rising edge detected internally.
- `exit_req` in 1: exit sensor, level; rising edge detected internally.
- `pw_in` in 4: password switches.
- `pw_valid` in 1: one-cycle pulse; sample `pw_in`.
- `segstate` out 2: message code to the display driver, registered.
- `gate_open` out 1: gate actuator, registered.
- `occupancy` out $clog2(CAPACITY+1): cars in lot, registered.
- `full` out 1: `occupancy == CAPACITY`, registered.

## Operation
- Edge detect: a `prev` register per request. An edge is `req & ~prev`; `prev` resets to 0.
- States: IDLE, WAIT_PW, ENTER, ERROR, plus LOCK (only with the macro). One 32-bit hold timer, cleared on every state change.
- IDLE:
  - `segstate` = 00 if `full`, else 11.
  - On an enter edge with `!full`, go to WAIT_PW.
  - An enter edge while `full` is ignored.
- WAIT_PW:
  - `segstate` = 11.
  - `pw_valid` with `pw_in == PW`: go to ENTER and increment occupancy.
  - `pw_valid` with a mismatch: go to ERROR.
  - Timer reaches `PW_TIMEOUT-1` with no `pw_valid`: go to ERROR.
  - If `pw_valid` arrives on the timeout cycle, `pw_valid` wins.
- ENTER:
  - `segstate` = 01, `gate_open` = 1.
  - After exactly `MSG_HOLD` cycles, go to IDLE.
  - Enter edges are ignored.
- ERROR:
  - `segstate` = 10, `gate_open` = 0.
  - After `MSG_HOLD` cycles, go to IDLE.
- Exit edge, accepted in any state: decrement occupancy if > 0; ignored at 0.
- Simultaneous entry increment and exit decrement in one cycle: occupancy is unchanged.
- Occupancy never exceeds `CAPACITY`: WAIT_PW is only entered when not full, and only one increment happens per WAIT_PW visit.
- `pw_valid` outside WAIT_PW is ignored.

## Timing
- Reset values: state IDLE, `segstate` = 11, `gate_open` = 0, `occupancy` = 0, `full` = 0, timer = 0, `prev` = 0, fail count = 0.
- Request to output latency: the edge is seen at clock edge N (first sample of 1). The state and registered outputs change from edge N onward, so they are visible in the cycle after N.
- `pw_valid` sampled at edge N:
  - ENTER outputs, the new `occupancy` and `full` are all valid after edge N, together.
- ENTER and ERROR hold: exactly `MSG_HOLD` cycles of `segstate` 01/10, then IDLE values.
- The `full` update is coincident with the `occupancy` update, with no extra cycle.
- `rst` asserted mid-sequence: all registers return to reset values at the next edge. An open gate closes and the occupancy count is lost.
- A request held high across reset release: since `prev` = 0 after reset, one edge is taken on the first post-reset cycle.

## Configuration
- `PARKING_LOCKOUT_EN`, when defined:
  - A 2-bit fail counter increments on each WAIT_PW→ERROR transition and clears on entry to ENTER.
  - On the 3rd consecutive failure, go to LOCK instead of ERROR. LOCK shows `segstate` = 10 for `4*MSG_HOLD` cycles and ignores enter edges; then go to IDLE with the counter cleared.
- When undefined: no LOCK state and no fail counter; every failure goes to ERROR.

## Test plan
All scenarios use `CAPACITY`=2, `MSG_HOLD`=4, `PW_TIMEOUT`=10.
- Reset, then idle 5 cycles -> `segstate` = 11, `gate_open` = 0, `occupancy` = 0, `full` = 0.
- Enter edge, then `pw_valid` with `pw_in` = 1010 -> `segstate` = 01 and `gate_open` = 1 for exactly 4 cycles, `occupancy` = 1, then `segstate` = 11.
- Two successful entries -> `full` = 1, `segstate` = 00. A third enter edge -> state stays IDLE and `occupancy` stays 2. Exit edge -> `occupancy` = 1, `segstate` = 11.
- Wrong password 0101 -> `segstate` = 10 for 4 cycles, `occupancy` unchanged. No password for 10 cycles -> Error. `pw_valid` on the timeout cycle -> accepted.
- Exit edge in the same cycle as a correct `pw_valid` at `occupancy` = 1 -> `occupancy` stays 1. Exit edge at `occupancy` = 0 -> stays 0. `rst` during ENTER -> all reset values on the next cycle.
- With `PARKING_LOCKOUT_EN`: three wrong passwords -> `segstate` = 10 for 16 cycles with enter edges ignored, then IDLE. Without the macro -> the third failure holds Error for 4 cycles only.
